// File: rtl/fake_netlist_bist_pkg.sv
// Shared types and step functions for the fake-netlist BIST wrappers.
package fake_netlist_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int LFSR_W      = 5;
  localparam int LFSR_TAP_HI = 4;
  localparam int LFSR_TAP_LO = 2;

  localparam int              MISR_W    = 16;
  localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;

  // Fibonacci x^5+x^3+1; the all-zero state is never entered from a non-zero seed.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] p);
    return {p[LFSR_W-2:0], p[LFSR_TAP_HI] ^ p[LFSR_TAP_LO]};
  endfunction

  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] s,
                                                  input logic              b);
    logic f;
    f = s[MISR_W-1] ^ b;
    return {s[MISR_W-2:0], 1'b0} ^ (f ? MISR_POLY : '0);
  endfunction

endpackage

// File: rtl/fake_netlist_misr.sv
// Serial MISR (poly 16'h1021): clr has priority over en; holds otherwise.
module fake_netlist_misr
  import fake_netlist_bist_pkg::*;
#(
  parameter int SIG_W = MISR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_i,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr)     sig_d = '0;
    else if (en) sig_d = misr_next(sig_q, bit_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/fake_netlist_bist_ctrl.sv
// LFSR launch / MISR capture BIST stage around a 5-in/1-out fake netlist.
// Optional registered golden compare on pass_o when BIST_PASS_CHECK_EN is defined.
module fake_netlist_bist_ctrl
  import fake_netlist_bist_pkg::*;
#(
  parameter int              IN_W    = 5,
  parameter int              NUM_PAT = 31,
  parameter int              SIG_W   = 16,
  parameter logic [IN_W-1:0] SEED    = 5'h01
`ifdef BIST_PASS_CHECK_EN
  ,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = 16'h0000
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [IN_W-1:0]  pattern_o,
  input  logic             resp_i,
  output logic [SIG_W-1:0] signature_o,
  output logic             pass_o,
  output logic [1:0]       state_o
);

  // Handshake: start is a one-cycle request, honoured only in IDLE or DONE;
  // busy marks the NUM_PAT apply cycles, done holds until the next start.
  localparam logic [IN_W-1:0] SEED_EFF = (SEED == '0) ? IN_W'(1) : SEED;
  localparam logic [IN_W-1:0] LAST_CNT = IN_W'(NUM_PAT - 1);

  state_t          state_q, state_d;
  logic [IN_W-1:0] pattern_q, pattern_d;
  logic [IN_W-1:0] cnt_q, cnt_d;
  logic            misr_clr, misr_en;

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    cnt_d     = cnt_q;
    misr_clr  = 1'b0;
    misr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        pattern_d = SEED_EFF;
        cnt_d     = '0;
        misr_clr  = 1'b1;
        if (start) state_d = RUN;
      end
      RUN: begin
        // resp_i belongs to the pattern retired on this same edge.
        misr_en   = 1'b1;
        pattern_d = lfsr_next(pattern_q);
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d   = RUN;
          pattern_d = SEED_EFF;
          cnt_d     = '0;
          misr_clr  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pattern_q <= SEED_EFF;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      cnt_q     <= cnt_d;
    end
  end

  fake_netlist_misr #(.SIG_W(SIG_W)) u_misr (
    .clk   (clk),
    .rst   (rst),
    .clr   (misr_clr),
    .en    (misr_en),
    .bit_i (resp_i),
    .sig   (signature_o)
  );

`ifdef BIST_PASS_CHECK_EN
  logic pass_q, pass_d;

  // Compare the value the MISR is about to take, so pass_o is valid with done.
  always_comb begin
    pass_d = pass_q;
    if (misr_clr)
      pass_d = 1'b0;
    else if (state_q == RUN && state_d == DONE)
      pass_d = (misr_next(signature_o, resp_i) == GOLDEN_SIG);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pass_q <= 1'b0;
    else     pass_q <= pass_d;
  end

  assign pass_o = pass_q;
`else
  assign pass_o = 1'b0;
`endif

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pattern_o = pattern_q;
  assign state_o   = state_q;

endmodule
